// File: rtl/dx_hazard_ctrl_pkg.sv
// Shared opcode/aluop constants, FSM state encoding and control-bundle type
// for the D/X hazard controller.
package dx_hazard_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} md_state_e;

  typedef struct packed {
    logic pcEn;
    logic fdEn;
    logic dxEn;
    logic fdFlush;
    logic dxBubble;
    logic xmBubble;
    logic ctrlMult;
    logic ctrlDiv;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pcEn: 1'b1, fdEn: 1'b1, dxEn: 1'b1, fdFlush: 1'b0,
                                 dxBubble: 1'b0, xmBubble: 1'b0, ctrlMult: 1'b0,
                                 ctrlDiv: 1'b0};

  function automatic logic is_muldiv(input logic [4:0] op, input logic [4:0] aluop);
    return (op == OP_RTYPE) && ((aluop == ALU_MULT) || (aluop == ALU_DIV));
  endfunction

endpackage

// File: rtl/dx_hazard_ctrl_if.sv
// Decode/execute-side signal bundle: pipeline-latch fields in, latch enables
// and mult/div sequencing out.
interface dx_hazard_ctrl_if;
  logic [4:0] dxOpcode;
  logic [4:0] dxAluop;
  logic [4:0] dxRd;
  logic [4:0] fdOpcode;
  logic [4:0] fdRs;
  logic [4:0] fdRt;
  logic       mdResultRdy;
  logic       branchTaken;
  logic       pcEn;
  logic       fdEn;
  logic       dxEn;
  logic       fdFlush;
  logic       dxBubble;
  logic       xmBubble;
  logic       ctrlMult;
  logic       ctrlDiv;
  logic       mdBusy;
  logic       mdTimeout;

  modport master (
    output dxOpcode, dxAluop, dxRd, fdOpcode, fdRs, fdRt, mdResultRdy, branchTaken,
    input  pcEn, fdEn, dxEn, fdFlush, dxBubble, xmBubble, ctrlMult, ctrlDiv, mdBusy, mdTimeout
  );

  modport slave (
    input  dxOpcode, dxAluop, dxRd, fdOpcode, fdRs, fdRt, mdResultRdy, branchTaken,
    output pcEn, fdEn, dxEn, fdFlush, dxBubble, xmBubble, ctrlMult, ctrlDiv, mdBusy, mdTimeout
  );
endinterface

// File: rtl/dx_hazard_ctrl_src_decode.sv
// Which register fields the F/D instruction actually reads as sources.
module dx_src_decode
  import dx_hazard_ctrl_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic       usesRs_o,
  output logic       usesRt_o
);
  assign usesRs_o = !((opcode_i == OP_J) || (opcode_i == OP_JAL) || (opcode_i == OP_SETX));

  // JR reads its target through the rt slot, so it counts as an rt reader.
  assign usesRt_o = (opcode_i == OP_RTYPE) || (opcode_i == OP_SW) || (opcode_i == OP_BNE) ||
                    (opcode_i == OP_BLT)   || (opcode_i == OP_JR);
endmodule

// File: rtl/dx_hazard_ctrl.sv
// D/X hazard controller: load-use stalls, branch flushes and mult/div
// start/busy/done sequencing with a bounded busy timeout.
module dx_hazard_ctrl
  import dx_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input logic           clock,
  input logic           reset,
  dx_hazard_ctrl_if.slave bus
);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  logic usesRs, usesRt, dxMuldiv, loadUse;
  ctrl_t ctrl;

  dx_src_decode u_src_decode (
    .opcode_i (bus.fdOpcode),
    .usesRs_o (usesRs),
    .usesRt_o (usesRt)
  );

  assign dxMuldiv = is_muldiv(bus.dxOpcode, bus.dxAluop);
  assign loadUse  = (bus.dxOpcode == OP_LW) && (bus.dxRd != 5'd0) &&
                    ((usesRs && (bus.fdRs == bus.dxRd)) || (usesRt && (bus.fdRt == bus.dxRd)));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (dxMuldiv) begin
          state_q <= ST_BUSY;
          cnt_q   <= '0;
        end
        ST_BUSY: begin
          if (bus.mdResultRdy) begin
            state_q <= ST_DONE;
          end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= ST_DONE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_RUN;
    unique case (state_q)
      ST_IDLE: begin
        if (dxMuldiv) begin
          ctrl.pcEn     = 1'b0;
          ctrl.fdEn     = 1'b0;
          ctrl.dxEn     = 1'b0;
          ctrl.xmBubble = 1'b1;
          ctrl.ctrlMult = (bus.dxAluop == ALU_MULT);
          ctrl.ctrlDiv  = (bus.dxAluop == ALU_DIV);
        end else if (bus.branchTaken) begin
          ctrl.fdFlush  = 1'b1;
          ctrl.dxBubble = 1'b1;
        end else if (loadUse) begin
          ctrl.pcEn     = 1'b0;
          ctrl.fdEn     = 1'b0;
          ctrl.dxBubble = 1'b1;
        end
      end
      ST_BUSY: begin
        ctrl.pcEn     = 1'b0;
        ctrl.fdEn     = 1'b0;
        ctrl.dxEn     = 1'b0;
        ctrl.xmBubble = 1'b1;
      end
      // Result drains into X/M while the mult/div leaves D/X as a bubble.
      ST_DONE: ctrl.dxBubble = 1'b1;
      default: ctrl = CTRL_RUN;
    endcase
    // A reset cycle must never launch a pulse or hold the pipe.
    if (!reset) ctrl = CTRL_RUN;
  end

  assign bus.pcEn      = ctrl.pcEn;
  assign bus.fdEn      = ctrl.fdEn;
  assign bus.dxEn      = ctrl.dxEn;
  assign bus.fdFlush   = ctrl.fdFlush;
  assign bus.dxBubble  = ctrl.dxBubble;
  assign bus.xmBubble  = ctrl.xmBubble;
  assign bus.ctrlMult  = ctrl.ctrlMult;
  assign bus.ctrlDiv   = ctrl.ctrlDiv;
  assign bus.mdBusy    = reset && (state_q == ST_BUSY);
  assign bus.mdTimeout = timeout_q;

endmodule
